// File: rtl/data_sram_resp_pkg.sv
// Shared constants and types for the data SRAM responder.
// Holds parameter defaults, FSM encoding and counter helpers.
package data_sram_resp_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int LATENCY_DEF = 1;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // WAIT is entered after the acceptance edge and RESP takes one more
  // cycle, so the counter starts two below the latency.
  function automatic logic [CNT_W-1:0] cnt_init(input int lat);
    return (lat > 1) ? CNT_W'(lat - 2) : '0;
  endfunction

endpackage

// File: rtl/dsram_bytewe_ram.sv
// Single-port word RAM with byte-lane write enables.
// The read lands in a registered rdata that holds until the next read.
module dsram_bytewe_ram
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Array is deliberately left without reset so stores survive it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Request/response front end for the data SRAM.
// One request in flight; response arrives LATENCY cycles after accept.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    cnt_init(LATENCY);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx;
  logic              can_take;
  logic              accept;

  assign idx = data_sram_addr[ADDR_W+1:2];

  assign can_take = (state == IDLE) |
                    (state == RESP);

  // Reset masks both handshakes so nothing is taken or reported.
  assign data_sram_addr_ok = ~reset & can_take;
  assign data_sram_data_ok = ~reset &
                             (state == RESP);

  assign accept = data_sram_req &
                  data_sram_addr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dsram_bytewe_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (accept & data_sram_wr),
    .re    (accept & ~data_sram_wr),
    .wstrb (data_sram_wstrb),
    .idx   (idx),
    .wdata (data_sram_wdata),
    .rdata (data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three latencies driven by one stimulus.
// A due-cycle model predicts every output; literal checks pin it.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  aok;
  logic [2:0]  dok;
  logic [31:0] rd [3];

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(10), .LATENCY(1)) u1 (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (aok[0]),
    .data_sram_data_ok (dok[0]),
    .data_sram_rdata   (rd[0])
  );

  data_sram_resp #(.ADDR_W(10), .LATENCY(3)) u3 (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (aok[1]),
    .data_sram_data_ok (dok[1]),
    .data_sram_rdata   (rd[1])
  );

  data_sram_resp #(.ADDR_W(10), .LATENCY(4)) u4 (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (aok[2]),
    .data_sram_data_ok (dok[2]),
    .data_sram_rdata   (rd[2])
  );

  // Model: each instance either is free or owes a response at due_m.
  int          lat [3] = '{1, 3, 4};
  bit          out_m [3];
  longint      due_m [3];
  logic [31:0] rd_m [3];
  logic [31:0] mem_m [int];
  longint      cyc = 0;
  int          pass_n = 0;
  int          total_n = 0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      out_m[k] = 1'b0;
      due_m[k] = 0;
      rd_m[k]  = 'x;
    end
  end

  function automatic bit ok_m(input int k);
    return !reset && (!out_m[k] || due_m[k] == cyc);
  endfunction

  function automatic bit dok_m(input int k);
    return !reset && out_m[k] && due_m[k] == cyc;
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s[%0d] got %h want %h cycle %0d",
                  nm, k, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        out_m[k] = 1'b0;
        rd_m[k]  = 32'h0;
      end else begin
        bit acc;
        int key;
        logic [31:0] w;
        acc = req && ok_m(k);
        if (out_m[k] && due_m[k] == cyc) out_m[k] = 1'b0;
        if (acc) begin
          key = k * 1024 + int'(addr[11:2]);
          out_m[k] = 1'b1;
          due_m[k] = cyc + lat[k];
          w = mem_m.exists(key) ? mem_m[key] : 32'hx;
          if (wr) begin
            for (int i = 0; i < 4; i++)
              if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
            mem_m[key] = w;
          end else begin
            rd_m[k] = w;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("addr_ok", k, 32'(aok[k]), 32'(ok_m(k)));
      chk("data_ok", k, 32'(dok[k]), 32'(dok_m(k)));
      if (!$isunknown(rd_m[k]))
        chk("rdata", k, rd[k], rd_m[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    wstrb = s;
  endtask

  task automatic settle(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_aok", 0, 32'(aok[0]), 32'd1);
    chk("post_rst_rd", 0, rd[0], 32'h0);

    // Seed a word, then reset with a full store pending on it.
    put(1, 32'h40, 32'hDEADBEEF, 4'hF);
    step();
    settle(6);
    reset = 1'b1;
    put(1, 32'h40, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_dok", 0, 32'(dok[0]), 32'd0);
      step();
    end
    reset = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    chk("rel_aok", 0, 32'(aok[0]), 32'd1);
    put(0, 32'h40, 32'h0, 4'h0);
    step();
    req = 1'b0;
    @(negedge clk);
    chk("rst_nowrite", 0, rd[0], 32'hDEADBEEF);
    settle(6);

    // Store then back-to-back load.
    put(1, 32'h10, 32'h8899AABB, 4'hF);
    step();
    put(0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk("st_dok", 0, 32'(dok[0]), 32'd1);
    step();
    req = 1'b0;
    @(negedge clk);
    chk("ld_dok", 0, 32'(dok[0]), 32'd1);
    chk("ld_rd", 0, rd[0], 32'h8899AABB);
    settle(6);

    // Single byte lane 2 store.
    put(1, 32'h12, 32'h00550000, 4'b0100);
    step();
    put(0, 32'h10, 32'h0, 4'h0);
    step();
    req = 1'b0;
    @(negedge clk);
    chk("lane_rd", 0, rd[0], 32'h8855AABB);
    settle(6);

    // Latency 3 timing on u3.
    put(0, 32'h10, 32'h0, 4'h0);
    step();
    req = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk("l3_aok_lo", 1, 32'(aok[1]), 32'd0);
      chk("l3_dok_lo", 1, 32'(dok[1]), 32'd0);
      step();
    end
    @(negedge clk);
    chk("l3_dok", 1, 32'(dok[1]), 32'd1);
    chk("l3_aok", 1, 32'(aok[1]), 32'd1);
    chk("l3_rd", 1, rd[1], 32'h8855AABB);
    put(0, 32'h40, 32'h0, 4'h0);
    step();
    req = 1'b0;
    for (int i = 4; i <= 5; i++) begin
      @(negedge clk);
      chk("l3b_dok_lo", 1, 32'(dok[1]), 32'd0);
      step();
    end
    @(negedge clk);
    chk("l3b_dok", 1, 32'(dok[1]), 32'd1);
    chk("l3b_rd", 1, rd[1], 32'hDEADBEEF);
    settle(6);

    // Address aliasing above bit 11, then a zero-strobe store.
    put(1, 32'h1000_0004, 32'h12345678, 4'hF);
    step();
    put(0, 32'h0000_0004, 32'h0, 4'h0);
    step();
    req = 1'b0;
    @(negedge clk);
    chk("alias_rd", 0, rd[0], 32'h12345678);
    settle(6);
    put(1, 32'h4, 32'hFFFFFFFF, 4'h0);
    step();
    req = 1'b0;
    @(negedge clk);
    chk("zstrb_dok", 0, 32'(dok[0]), 32'd1);
    settle(6);
    put(0, 32'h4, 32'h0, 4'h0);
    step();
    req = 1'b0;
    @(negedge clk);
    chk("zstrb_rd", 0, rd[0], 32'h12345678);
    settle(6);

    // Reset while u4 is waiting on a load.
    put(0, 32'h40, 32'h0, 4'h0);
    step();
    req   = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_dok", 2, 32'(dok[2]), 32'd0);
      step();
    end
    @(negedge clk);
    chk("midrst_rd", 2, rd[2], 32'h0);
    chk("midrst_aok", 2, 32'(aok[2]), 32'd1);
    step();

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
